// File: rtl/uart_tx_serializer_if.sv
// Byte-source handshake for the UART transmitter.
//   tx_data     : byte to send, sampled only on an accepting edge
//   tx_transmit : valid, request to send tx_data
//   tx_ready    : transmitter idle and able to accept a byte
//   tx_done     : one-cycle pulse at the end of each frame
// master = byte source (handler), slave = serializer.
interface uart_tx_serializer_if;
  logic [7:0] tx_data;
  logic       tx_transmit;
  logic       tx_ready;
  logic       tx_done;

  modport master (output tx_data, tx_transmit, input tx_ready, tx_done);
  modport slave  (input tx_data, tx_transmit, output tx_ready, tx_done);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte per valid/ready handshake, sent 8N1
// (8E1 when UART_TX_PARITY_EN is defined), LSB first, on the tx pin.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after bit 7).
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : slave side of uart_tx_serializer_if (tx_data/tx_transmit in,
//           tx_ready/tx_done out)
//   tx    : serial line, idle high
// Parameters: CLKS_PER_BIT (>= 2), STOP_BITS (1 or 2), CNT_BITS
// (2**CNT_BITS >= CLKS_PER_BIT).
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int CNT_BITS     = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_serializer_if.slave   bus,
  output logic                  tx
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [CNT_BITS-1:0] LAST_CNT  = CNT_BITS'(CLKS_PER_BIT - 1);
  localparam logic                LAST_STOP = 1'(STOP_BITS - 1);

  state_t              state;
  logic [CNT_BITS-1:0] baudCnt;
  logic [2:0]          bitIdx;
  logic                stopIdx;
  logic [7:0]          shiftReg;
  logic                txReady;
  logic                txDone;
`ifdef UART_TX_PARITY_EN
  logic                parityBit;
`endif

  wire bitEnd = (baudCnt == LAST_CNT);

  assign bus.tx_ready = txReady;
  assign bus.tx_done  = txDone;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      txReady  <= 1'b1;
      txDone   <= 1'b0;
      baudCnt  <= '0;
      bitIdx   <= '0;
      stopIdx  <= 1'b0;
      shiftReg <= '0;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      txDone <= 1'b0;
      // Baud counter wraps on every bit boundary; idle keeps it at zero.
      if (state == IDLE || bitEnd) baudCnt <= '0;
      else                         baudCnt <= baudCnt + CNT_BITS'(1);

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (bus.tx_transmit) begin
            shiftReg <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
            parityBit <= ^bus.tx_data;
`endif
            tx      <= 1'b0;
            txReady <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            tx    <= shiftReg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bitEnd) begin
            // tx is loaded from the register one bit ahead, so equal
            // adjacent bits never produce a transition.
            shiftReg <= shiftReg >> 1;
            if (bitIdx == 3'd7) begin
              bitIdx <= '0;
`ifdef UART_TX_PARITY_EN
              tx    <= parityBit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bitIdx <= bitIdx + 3'd1;
              tx     <= shiftReg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bitEnd) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bitEnd) begin
            if (stopIdx == LAST_STOP) begin
              stopIdx <= 1'b0;
              txReady <= 1'b1;
              txDone  <= 1'b1;
              state   <= IDLE;
            end else begin
              stopIdx <= ~stopIdx;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          txReady <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx0, tx1;
  logic sel = 1'b0;   // 0: one-stop-bit DUT, 1: two-stop-bit DUT
  int checks = 0;
  int errors = 0;
  bit expBits[$];
  logic lastPar;

  uart_tx_serializer_if if0 ();
  uart_tx_serializer_if if1 ();

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .CNT_BITS(3)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .tx(tx0));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .CNT_BITS(3)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .tx(tx1));

  always #5 clk = ~clk;

  wire curTx    = sel ? tx1 : tx0;
  wire curReady = sel ? if1.tx_ready : if0.tx_ready;
  wire curDone  = sel ? if1.tx_done : if0.tx_done;

  typedef struct {
    logic [7:0] data;
    bit         hold;
    int         busyAt;
    bit         expPar;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setIn(input logic [7:0] d, input logic t);
    if (sel) begin
      if1.tx_data = d; if1.tx_transmit = t; if0.tx_transmit = 1'b0;
    end else begin
      if0.tx_data = d; if0.tx_transmit = t; if1.tx_transmit = 1'b0;
    end
  endtask

  // Reference frame: start, 8 data bits LSB first, optional even parity, stops.
  task automatic buildFrame(input logic [7:0] d, input int stops);
    expBits.delete();
    expBits.push_back(1'b0);
    for (int i = 0; i < 8; i++) expBits.push_back(d[i]);
    if (PAR == 1) expBits.push_back(^d);
    for (int i = 0; i < stops; i++) expBits.push_back(1'b1);
  endtask

  // Called on a negedge; accepts d on the next posedge and checks every
  // cycle of the frame plus the return-to-idle edge.
  task automatic sendFrame(input logic [7:0] d, input bit hold, input int busyAt);
    int fl;
    buildFrame(d, sel ? 2 : 1);
    fl = expBits.size() * CPB;
    lastPar = 1'bx;
    setIn(d, 1'b1);
    chk($sformatf("ready_before d=%02h", d), 32'(curReady), 32'd1);
    @(posedge clk);
    @(negedge clk);
    setIn(8'($urandom), hold);   // post-accept data changes must not matter
    for (int k = 0; k < fl; k++) begin
      if (k == busyAt)     setIn(8'h3C, 1'b1);
      if (k == busyAt + 1) setIn(8'h3C, hold);
      chk($sformatf("frame d=%02h k=%0d {tx,ready,done}", d, k),
          32'({curTx, curReady, curDone}), 32'({expBits[k / CPB], 2'b00}));
      if (k == 9 * CPB + 1) lastPar = curTx;
      @(negedge clk);
    end
    chk($sformatf("frame_end d=%02h {tx,ready,done}", d),
        32'({curTx, curReady, curDone}), 32'b111);
  endtask

  task automatic idleCheck(input int n);
    setIn(8'h00, 1'b0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("idle k=%0d {tx,ready,done}", k),
          32'({curTx, curReady, curDone}), 32'b110);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, -1, 1'b0};
    vecs[1] = '{8'h07, 1'b0, -1, 1'b1};
    vecs[2] = '{8'h00, 1'b1, -1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, -1, 1'b0};
    vecs[4] = '{8'h55, 1'b0, 12, 1'b0};
    vecs[5] = '{8'h81, 1'b0, -1, 1'b0};

    if0.tx_data = '0; if0.tx_transmit = 1'b0;
    if1.tx_data = '0; if1.tx_transmit = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset dut0 {tx,ready,done}", 32'({tx0, if0.tx_ready, if0.tx_done}), 32'b110);
    chk("reset dut1 {tx,ready,done}", 32'({tx1, if1.tx_ready, if1.tx_done}), 32'b110);
    reset = 1'b0;
    idleCheck(2);

    // Table: single byte, parity cases, back-to-back 00->FF, busy ignore.
    for (int v = 0; v < 6; v++) begin
      sendFrame(vecs[v].data, vecs[v].hold, vecs[v].busyAt);
`ifdef UART_TX_PARITY_EN
      chk($sformatf("parity d=%02h", vecs[v].data), 32'(lastPar), 32'(vecs[v].expPar));
`endif
      if (!vecs[v].hold) idleCheck(2);
    end

    // Reset during data bit 3 of 0x81, then a clean retry.
    setIn(8'h81, 1'b1);
    @(posedge clk);
    @(negedge clk);
    setIn(8'h00, 1'b0);
    repeat (17) @(negedge clk);
    chk("pre-reset in bit3", 32'({curTx, curReady}), 32'b00);
    reset = 1'b1;
    @(negedge clk);
    chk("reset midframe {tx,ready,done}", 32'({curTx, curReady, curDone}), 32'b110);
    reset = 1'b0;
    @(negedge clk);
    chk("after reset {tx,ready,done}", 32'({curTx, curReady, curDone}), 32'b110);
    sendFrame(8'h81, 1'b0, -1);
    idleCheck(1);

    // Randomized traffic against the frame model.
    repeat (20) begin
      logic [7:0] d;
      bit h;
      int b;
      d = 8'($urandom);
      h = 1'($urandom_range(0, 1));
      b = $urandom_range(0, 1) ? $urandom_range(1, 9 * CPB) : -1;
      sendFrame(d, h, b);
    end
    idleCheck(2);

    // Two stop bits.
    sel = 1'b1;
    idleCheck(1);
    sendFrame(8'h01, 1'b0, -1);
    idleCheck(1);
    repeat (4) sendFrame(8'($urandom), 1'($urandom_range(0, 1)), -1);
    idleCheck(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit half of the board UART. It accepts one byte per valid/ready handshake from a RAM-backed handler or other byte source, and serializes it onto the RS232 TX line as 8N1 (optionally 8E1), LSB first. It sits between the handler's `tx_data`/`tx_transmit`/`tx_ready` interface and the `UART_TX` pin. It runs entirely in the `clk` domain, with no external baud clock.

Parameters:
- `CLKS_PER_BIT`, default 434, clk cycles per serial bit (50 MHz / 115200). Legal range ≥ 2.
- `STOP_BITS`, default 1, number of stop bits. Legal values: 1 or 2.
- `CNT_BITS`, default 9, width of the baud counter. Must satisfy 2^`CNT_BITS` ≥ `CLKS_PER_BIT`.

Ports:
- `clk`  input  1  system clock
- `reset`  input  1  synchronous, active-high reset
- `tx_data`  input  8  byte to send; sampled only on an accepting edge
- `tx_transmit`  input  1  valid; request to send `tx_data`
- `tx_ready`  output  1  high when idle and able to accept a byte
- `tx_done`  output  1  one-cycle pulse at the end of each frame
- `tx`  output  1  serial line; idle high

Behaviour:
- Reset: `reset` is synchronous, active-high; clock is `clk`.
  - Next edge after reset: `state` = IDLE, `tx` = 1, `tx_ready` = 1, `tx_done` = 0, counters = 0.
  - Reset mid-frame aborts the frame. `tx` returns to 1 on that edge; no `tx_done` is issued.
- All outputs are registered. `tx_ready` is high exactly while `state` = IDLE.
- Handshake:
  - Accept occurs on an edge where `tx_ready` = 1 and `tx_transmit` = 1.
  - On that edge: latch `tx_data` into a shift register, set `tx` = 0 (start bit), leave IDLE. `tx_ready` = 0 from that edge.
  - `tx_transmit` while busy is ignored. The byte is not queued.
  - `tx_data` changes after acceptance have no effect on the frame.
- States:
  - IDLE: `tx` = 1. On accept, go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7. After bit 7, go to PARITY if the feature is enabled, else STOP.
  - PARITY (feature only): `tx` = parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx` = 1 for `STOP_BITS` × `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - Cleared on accept and in IDLE.
- Frame length (accept edge to return to IDLE) = (1 + 8 + P + `STOP_BITS`) × `CLKS_PER_BIT` cycles, where P = 1 with parity, else 0.
- `tx_done`:
  - Pulses high for exactly one cycle, on the same edge that `state` returns to IDLE and `tx_ready` rises.
  - Back-to-back: if `tx_transmit` is held high, the next accept happens the edge after `tx_ready` rises. The line then shows exactly one idle-high cycle between frames.
- Data 0x00 and 0xFF need no special handling. The line must not glitch between bits of equal value.

Optional Feature:
Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state is inserted after bit 7. The parity bit is even parity, i.e. the XOR of the 8 latched data bits. Frame = 11 bits at `STOP_BITS` = 1.
- Undefined: the PARITY state and parity logic are absent. Frame = 10 bits at `STOP_BITS` = 1. Timing is otherwise identical.

Test Plan:
1. Single byte. `CLKS_PER_BIT` = 4, no parity; accept 0xA5.
   - `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
   - `tx_ready` low for 40 cycles; `tx_done` pulses once at cycle 40.
2. Parity. Build with `UART_TX_PARITY_EN`, `CLKS_PER_BIT` = 4.
   - 0xA5 gives parity bit 0; frame is 44 cycles.
   - 0x07 gives parity bit 1, placed between data bit 7 and the stop bit.
3. Back-to-back. Hold `tx_transmit` = 1 with 0x00 then 0xFF.
   - Two frames with exactly one idle-high cycle between them; exactly two `tx_done` pulses.
   - 0xFF data bits show no glitch.
4. Busy ignore. Pulse `tx_transmit` with 0x3C while mid-frame of 0x55.
   - Only the 0x55 frame is emitted.
   - 0x3C is never sent; `tx_ready` stays low until the 0x55 frame ends.
5. Reset mid-frame. Assert `reset` during data bit 3 of 0x81.
   - Next edge: `tx` = 1, `tx_ready` = 1, no `tx_done`.
   - A subsequent 0x81 transmits a complete, correct frame.
6. Two stop bits. `STOP_BITS` = 2, `CLKS_PER_BIT` = 4, send 0x01.
   - Stop phase = 8 cycles high; frame = 44 cycles; `tx_done` pulses at cycle 44.
